// File: rtl/hyperbus_pkg.sv
// HyperBus config register map, boot defaults and init FSM state encoding.
package hyperbus_pkg;

    // Config register indices (word addresses)
    localparam int unsigned RegTLatAccess     = 0;
    localparam int unsigned RegEnLatAdditional = 1;
    localparam int unsigned RegTCsMax         = 2;
    localparam int unsigned RegTRwRecovery    = 3;
    localparam int unsigned RegTRwdsDelay     = 4;
    localparam int unsigned RegTVarLatCheck   = 5;
    // First of the per-chip start/end address pairs
    localparam int unsigned RegAddrMapBase    = 6;

    // Boot values for the registers that are not parameterised
    localparam logic [31:0] DefEnLatAdditional = 32'd1;
    localparam logic [31:0] DefTRwRecovery     = 32'd6;
    localparam logic [31:0] DefTRwdsDelay      = 32'd2;
    localparam logic [31:0] DefTVarLatCheck    = 32'd3;

    typedef enum logic [1:0] {
        StWrite = 2'd0,
        StPass  = 2'd1
    } state_e;

endpackage

// File: rtl/reg_intf_pkg.sv
// Register-interface request/response payloads shared by host, init block and config file.
package reg_intf_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req_a32_d32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp_d32;

endpackage

// File: rtl/hyperbus_cfg_init.sv
// Boot-time initialiser for the HyperBus config register file: writes the
// default register set and chip address map, then hands the port to software.
module hyperbus_cfg_init
    import reg_intf_pkg::*;
    import hyperbus_pkg::*;
#(
    parameter int unsigned NumChips   = 2,
    parameter logic [31:0] ChipSpan   = 32'h40_0000,
    parameter int unsigned TLatAccess = 6,
    parameter int unsigned TCsMax     = 665
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       reinit_i,
    input  req_a32_d32 host_req_i,
    output rsp_d32     host_rsp_o,
    output req_a32_d32 cfg_req_o,
    input  rsp_d32     cfg_rsp_i,
    output logic       init_done_o,
    output logic       init_error_o
);

    localparam int unsigned NumRegs = 2 * NumChips + 6;
    localparam int unsigned CntW    = $clog2(NumRegs);
    localparam logic [CntW-1:0] LastIdx = CntW'(NumRegs - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] k_q, k_d;
    logic            pending_q, pending_d;
    logic            error_q, error_d;
    logic            host_idle;

    // Boot value for init write k: fixed registers first, then start/end pairs per chip
    function automatic logic [31:0] init_wdata(input logic [CntW-1:0] k);
        logic [31:0] idx;
        logic [31:0] j;
        idx = 32'(k);
        j   = (idx - 32'(RegAddrMapBase)) >> 1;
        case (idx)
            32'(RegTLatAccess):      init_wdata = 32'(TLatAccess);
            32'(RegEnLatAdditional): init_wdata = DefEnLatAdditional;
            32'(RegTCsMax):          init_wdata = 32'(TCsMax);
            32'(RegTRwRecovery):     init_wdata = DefTRwRecovery;
            32'(RegTRwdsDelay):      init_wdata = DefTRwdsDelay;
            32'(RegTVarLatCheck):    init_wdata = DefTVarLatCheck;
            default:                 init_wdata = idx[0] ? ChipSpan * (j + 32'd1)
                                                         : ChipSpan * j;
        endcase
    endfunction

    // State, write index, pending reinit and sticky error registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StWrite;
            k_q       <= '0;
            pending_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pending_q <= pending_d;
            error_q   <= error_d;
        end
    end

    // Next-state and port muxing: init writes in WRITE, zero-latency passthrough in PASS
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        pending_d  = pending_q;
        error_d    = error_q;
        cfg_req_o  = '0;
        host_rsp_o = '0;
        host_idle  = 1'b0;

        case (state_q)
            StWrite: begin
                cfg_req_o.valid = 1'b1;
                cfg_req_o.write = 1'b1;
                cfg_req_o.wstrb = 4'hF;
                cfg_req_o.addr  = 32'(k_q) << 2;
                cfg_req_o.wdata = init_wdata(k_q);
                if (cfg_rsp_i.ready) begin
                    if (cfg_rsp_i.error) begin
                        error_d = 1'b1;
                    end
                    if (k_q == LastIdx) begin
                        state_d = StPass;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + CntW'(1);
                    end
                end
            end
            StPass: begin
                cfg_req_o  = host_req_i;
                host_rsp_o = cfg_rsp_i;
                // Safe to take the port back only between host transactions
                host_idle  = !host_req_i.valid || cfg_rsp_i.ready;
                if ((reinit_i || pending_q) && host_idle) begin
                    state_d   = StWrite;
                    k_d       = '0;
                    pending_d = 1'b0;
                    error_d   = 1'b0;
                end else if (reinit_i) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d   = StWrite;
                k_d       = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    assign init_done_o  = (state_q == StPass);
    assign init_error_o = error_q;

endmodule

// File: tb/tb_hyperbus_cfg_init.sv
// Scoreboard bench for hyperbus_cfg_init: expected init writes and host responses
// are queued by the stimulus and consumed by an independent monitor.
module tb_hyperbus_cfg_init;
    import reg_intf_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_exp_t;

    typedef struct {
        logic        is_write;
        logic [31:0] rdata;
    } host_exp_t;

    logic       clk;
    logic       rst_n;
    logic       reinit;
    req_a32_d32 host_req;
    rsp_d32     host_rsp;
    req_a32_d32 cfg_req;
    rsp_d32     cfg_rsp;
    logic       init_done;
    logic       init_error;

    logic        cfg_ready;
    logic        err_en;
    logic [31:0] err_addr;
    logic [31:0] mem [16];

    cfg_exp_t  exp_q [$];
    host_exp_t host_q [$];

    int checks = 0;
    int failures = 0;
    int writes_total = 0;
    int host_hs_total = 0;

    hyperbus_cfg_init dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reinit_i     (reinit),
        .host_req_i   (host_req),
        .host_rsp_o   (host_rsp),
        .cfg_req_o    (cfg_req),
        .cfg_rsp_i    (cfg_rsp),
        .init_done_o  (init_done),
        .init_error_o (init_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Config register file model
    always_comb begin
        cfg_rsp       = '0;
        cfg_rsp.ready = cfg_ready;
        cfg_rsp.rdata = mem[cfg_req.addr[5:2]];
        cfg_rsp.error = err_en && cfg_req.valid && (cfg_req.addr == err_addr);
    end

    always @(posedge clk) begin
        if (cfg_req.valid && cfg_req.write && cfg_ready)
            mem[cfg_req.addr[5:2]] <= cfg_req.wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected NumChips=2 init sequence
    task automatic push_seq();
        logic [31:0] d [10];
        cfg_exp_t e;
        d = '{32'd6, 32'd1, 32'd665, 32'd6, 32'd2, 32'd3,
              32'h0, 32'h40_0000, 32'h40_0000, 32'h80_0000};
        for (int i = 0; i < 10; i++) begin
            e.addr = 32'(i * 4);
            e.data = d[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_writes(input int base, input int n);
        int cyc;
        cyc = 0;
        while ((writes_total - base) < n && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if ((writes_total - base) < n) chk("wait_writes_timeout", 32'(writes_total - base), 32'(n));
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            if (init_done) break;
            cnt++;
        end
        if (!init_done) chk("done_timeout", 32'(init_done), 32'd1);
    endtask

    task automatic pulse_reinit();
        @(posedge clk); #1;
        reinit = 1'b1;
        @(posedge clk); #1;
        reinit = 1'b0;
    endtask

    task automatic host_txn(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
        host_exp_t e;
        int base;
        int cyc;
        e.is_write = wr;
        e.rdata    = exp_rdata;
        host_q.push_back(e);
        base = host_hs_total;
        @(posedge clk); #1;
        host_req.valid = 1'b1;
        host_req.write = wr;
        host_req.addr  = addr;
        host_req.wdata = wdata;
        host_req.wstrb = 4'hF;
        cyc = 0;
        while (host_hs_total == base && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        if (host_hs_total == base) chk("host_timeout", 32'd0, 32'd1);
        #1;
        host_req = '0;
    endtask

    // Monitor: consumes init-write and host-response expectations on each handshake
    initial begin
        cfg_exp_t  ce;
        host_exp_t he;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!init_done && cfg_req.valid && cfg_rsp.ready) begin
                    if (exp_q.size() == 0) begin
                        chk("cfg_unexpected_write", cfg_req.addr, 32'hFFFF_FFFF);
                    end else begin
                        ce = exp_q.pop_front();
                        chk("cfg_addr", cfg_req.addr, ce.addr);
                        chk("cfg_wdata", cfg_req.wdata, ce.data);
                        chk("cfg_write_wstrb", 32'({cfg_req.write, cfg_req.wstrb}), 32'h1F);
                    end
                    writes_total++;
                end
                if (host_req.valid) begin
                    if (!init_done) begin
                        chk("host_ready_in_write", 32'(host_rsp.ready), 32'd0);
                        chk("host_rdata_in_write", host_rsp.rdata, 32'd0);
                    end else if (host_rsp.ready) begin
                        if (host_q.size() == 0) begin
                            chk("host_unexpected_rsp", 32'd1, 32'd0);
                        end else begin
                            he = host_q.pop_front();
                            if (!he.is_write) chk("host_rdata", host_rsp.rdata, he.rdata);
                            chk("host_error", 32'(host_rsp.error), 32'd0);
                        end
                        host_hs_total++;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        int base;

        rst_n     = 1'b0;
        reinit    = 1'b0;
        host_req  = '0;
        cfg_ready = 1'b1;
        err_en    = 1'b0;
        err_addr  = 32'd0;

        // Reset state and back-to-back boot sequence
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_error", 32'(init_error), 32'd0);
        chk("rst_cfg_addr", cfg_req.addr, 32'd0);
        chk("rst_host_ready", 32'(host_rsp.ready), 32'd0);
        push_seq();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_done(n);
        chk("boot_cycles_to_done", 32'(n), 32'd10);
        chk("boot_q_empty", 32'(exp_q.size()), 32'd0);
        chk("boot_error", 32'(init_error), 32'd0);

        // Config file stalls k=2 for three cycles
        base = writes_total;
        push_seq();
        pulse_reinit();
        wait_writes(base, 2);
        #1 cfg_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", cfg_req.addr, 32'h8);
            chk("stall_wdata", cfg_req.wdata, 32'd665);
            chk("stall_k_held", 32'(writes_total - base), 32'd2);
            @(posedge clk);
        end
        #1 cfg_ready = 1'b1;
        @(negedge clk);
        chk("stall_addr_last", cfg_req.addr, 32'h8);
        wait_done(n);
        chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

        // Host read issued during WRITE waits for PASS and sees the booted value
        push_seq();
        pulse_reinit();
        host_txn(1'b0, 32'h8, 32'd0, 32'd665);
        wait_done(n);
        chk("hostrd_q_empty", 32'(exp_q.size()), 32'd0);
        chk("hostrd_hq_empty", 32'(host_q.size()), 32'd0);

        // Error on k=4 is sticky; reinit during WRITE is ignored
        base     = writes_total;
        err_en   = 1'b1;
        err_addr = 32'h10;
        push_seq();
        pulse_reinit();
        chk("err_cleared_on_start", 32'(init_error), 32'd0);
        wait_writes(base, 4);
        @(negedge clk);
        chk("err_before_k4", 32'(init_error), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("err_after_k4", 32'(init_error), 32'd1);
        pulse_reinit();
        wait_done(n);
        err_en = 1'b0;
        chk("err_q_empty", 32'(exp_q.size()), 32'd0);
        chk("err_sticky_done", 32'(init_error), 32'd1);
        repeat (5) @(negedge clk);
        chk("no_queued_rerun", 32'(init_done), 32'd1);

        // Reinit while a host write is stalled: write finishes, then restart
        push_seq();
        cfg_ready = 1'b0;
        fork
            host_txn(1'b1, 32'h28, 32'hA5A5_0001, 32'd0);
            begin
                repeat (2) @(posedge clk);
                pulse_reinit();
                @(negedge clk);
                chk("pending_still_pass", 32'(init_done), 32'd1);
                @(posedge clk); #1;
                cfg_ready = 1'b1;
            end
        join
        @(negedge clk);
        chk("pending_entered_write", 32'(init_done), 32'd0);
        chk("pending_error_cleared", 32'(init_error), 32'd0);
        chk("pending_restart_addr", cfg_req.addr, 32'd0);
        chk("pending_hostwr_landed", mem[10], 32'hA5A5_0001);
        wait_done(n);
        chk("pending_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted at k=7 abandons the sequence; restart from addr 0
        base = writes_total;
        push_seq();
        pulse_reinit();
        wait_writes(base, 7);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_done", 32'(init_done), 32'd0);
        chk("midrst_error", 32'(init_error), 32'd0);
        chk("midrst_cfg_addr", cfg_req.addr, 32'd0);
        chk("midrst_cfg_wdata", cfg_req.wdata, 32'd6);
        chk("midrst_host_ready", 32'(host_rsp.ready), 32'd0);
        exp_q.delete();
        push_seq();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_done(n);
        chk("midrst_cycles_to_done", 32'(n), 32'd10);
        chk("midrst_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperbus_cfg_init.md
HYPERBUS_CFG_INIT -- requirements
Module: hyperbus_cfg_init

Interface
REQ-001 SHALL have parameter NumChips, default 2, number of HyperBus chips whose address ranges are programmed.
REQ-002 SHALL have parameter ChipSpan, default 32'h40_0000, byte span per chip.
REQ-003 SHALL have parameter TLatAccess, default 6, boot value for register 0 (t_latency_access).
REQ-004 SHALL have parameter TCsMax, default 665, boot value for register 2 (t_cs_max).
REQ-005 SHALL have clk_i, input, 1, sole clock; one clock domain.
REQ-006 SHALL have rst_ni, input, 1, reset, asynchronous active-low.
REQ-007 SHALL have reinit_i, input, 1, single-cycle request to rerun the init sequence.
REQ-008 SHALL have host_req_i, input, reg_intf_pkg::req_a32_d32, software register request.
REQ-009 SHALL have host_rsp_o, output, reg_intf_pkg::rsp_d32, response to software.
REQ-010 SHALL have cfg_req_o, output, reg_intf_pkg::req_a32_d32, request to the config register file.
REQ-011 SHALL have cfg_rsp_i, input, reg_intf_pkg::rsp_d32, config register file response.
REQ-012 SHALL have init_done_o, output, 1, high while the block is in PASS.
REQ-013 SHALL have init_error_o, output, 1, sticky flag set when any init write returns error.

Function
REQ-014 SHALL implement the FSM states WRITE (init writes, host stalled) and PASS (host passthrough).
REQ-015 SHALL drive NumRegs = 2*NumChips+6 init writes, index k = 0..NumRegs-1, with a counter of $clog2(NumRegs) bits.
REQ-016 SHALL drive each WRITE request as: valid=1, write=1, wstrb=4'hF, addr=32'(k*4).
REQ-017 SHALL use this wdata table: k0=TLatAccess, k1=1, k2=TCsMax, k3=6, k4=2, k5=3.
REQ-018 SHALL use, for k>=6 with j=(k-6)>>1, wdata = ChipSpan*j when k even and ChipSpan*(j+1) when k odd, computed modulo 2^32.
REQ-019 SHALL hold addr, wdata and valid stable in WRITE until cfg_rsp_i.ready=1, and advance k only on that cycle.
REQ-020 SHALL set init_error_o on any WRITE handshake with cfg_rsp_i.error=1 and still complete the sequence; errors do not abort it.
REQ-021 SHALL go to PASS on the handshake cycle of k=NumRegs-1, asserting init_done_o the next cycle.
REQ-022 SHALL, in WRITE, drive host_rsp_o.ready=0, error=0, rdata=0; the host request is ignored and not forwarded.
REQ-023 SHALL, in PASS, combinationally connect cfg_req_o=host_req_i and host_rsp_o=cfg_rsp_i, with zero added latency.
REQ-024 SHALL act on reinit_i in PASS once no host transaction is outstanding (host_req_i.valid=0, or a handshake completing this cycle), then enter WRITE with k=0 and clear init_error_o.
REQ-025 SHALL latch a reinit_i that arrives while a host transaction is outstanding in a pending flag and act on it per REQ-024.
REQ-026 SHALL ignore reinit_i while in WRITE; the sequence neither restarts nor queues a rerun.
REQ-027 SHALL drive cfg_req_o all-zero when not in WRITE and not in PASS, so that no X reaches the config register file.

Reset
REQ-028 SHALL reset asynchronously to: state WRITE, k=0, pending=0, init_error_o=0, init_done_o=0.
REQ-029 SHALL, when reset is asserted mid-sequence or mid-host-transaction, abandon that transaction and restart from k=0 after reset deassertion.

Structure
REQ-030 SHALL take config register indices (0..5), the chip-range base index 6, and the boot defaults for registers 1, 3, 4 and 5 from hyperbus_pkg.
REQ-031 SHALL be a single module with one FSM and no sub-module.

Verification
REQ-032 SHALL cover: reset, cfg ready always 1, NumChips=2 -> 10 writes on consecutive cycles at addr 0x0..0x24 with data 6,1,665,6,2,3,0,0x400000,0x400000,0x800000, then init_done_o=1 on cycle 11.
REQ-033 SHALL cover: cfg ready held low 3 cycles on k=2 -> addr 0x8 and data 665 held stable for 4 cycles, k advances once.
REQ-034 SHALL cover: cfg error=1 on k=4 -> init_error_o=1 from the next cycle, sequence completes, done=1.
REQ-035 SHALL cover: host read of addr 0x8 during WRITE -> host ready=0 until PASS; after PASS, rdata=665 passed through.
REQ-036 SHALL cover: reinit_i during a stalled host write in PASS -> host write completes, then WRITE restarts at k=0 with init_error_o cleared.
REQ-037 SHALL cover: rst_ni low at k=7 -> outputs at reset values; after release, writes restart at addr 0x0.
